// File: rtl/udp_pkg.sv
// Shared definitions for the UDP transmit path: scheduler state encoding,
// timing defaults, counter widths and the frame constants used by the transmitter.
package udp_pkg;

    typedef logic [1:0] sched_state_t;

    localparam sched_state_t ST_IDLE = 2'd0;
    localparam sched_state_t ST_WAIT = 2'd1;
    localparam sched_state_t ST_GAP  = 2'd2;

    localparam int DEF_IFG_CYCLES     = 12;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    localparam int SENT_COUNT_W  = 32;
    localparam int ABORT_COUNT_W = 16;

    // The gap counter needs at least one bit even when no gap is configured.
    function automatic int gap_cnt_w(input int ifg);
        int w;
        w = $clog2(ifg + 1);
        return (w < 1) ? 1 : w;
    endfunction

    localparam logic [47:0] FRAME_SRC_MAC  = 48'h02_00_00_00_00_01;
    localparam logic [47:0] FRAME_DST_MAC  = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [31:0] FRAME_SRC_IP   = 32'hC0A8_0164;
    localparam logic [31:0] FRAME_DST_IP   = 32'hC0A8_01FF;
    localparam logic [15:0] FRAME_SRC_PORT = 16'd5000;
    localparam logic [15:0] FRAME_DST_PORT = 16'd5001;

endpackage

// File: rtl/udp_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request bit searching upward
// from the slot after rr_last, wrapping modulo NUM_REQ.
module rr_arbiter
    import udp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_last,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IDX_W'((int'(rr_last) + i) % NUM_REQ);
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/udp_tx_scheduler.sv
// Round-robin scheduler sharing one UDP/GMII transmitter between NUM_REQ sources.
// Handshake: send_packet is a one-cycle request; packet_sent is a one-cycle completion.
module udp_tx_scheduler
    import udp_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int IFG_CYCLES     = DEF_IFG_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [NUM_REQ-1:0]       req,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic [NUM_REQ-1:0]       err,
    output logic                     send_packet,
    input  logic                     packet_sent,
    output logic                     busy,
    output logic                     timeout_flag,
    output logic [SENT_COUNT_W-1:0]  sent_count,
    output logic [ABORT_COUNT_W-1:0] abort_count,
    output sched_state_t             state
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam int GAP_W = gap_cnt_w(IFG_CYCLES);

    localparam logic [IDX_W-1:0] RR_RESET  = IDX_W'(NUM_REQ - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
    localparam logic             GAP_USED  = (IFG_CYCLES > 0);
    // With no gap the done/err cycle is already an IDLE cycle.
    localparam sched_state_t     ST_AFTER  = (IFG_CYCLES > 0) ? ST_GAP : ST_IDLE;

    logic [IDX_W-1:0] rr_last;
    logic [TMR_W-1:0] timer;
    logic [GAP_W-1:0] gap_cnt;
    logic [IDX_W-1:0] winner;
    logic             arb_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req     (req),
        .rr_last (rr_last),
        .winner  (winner),
        .valid   (arb_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            grant        <= '0;
            done         <= '0;
            err          <= '0;
            send_packet  <= 1'b0;
            busy         <= 1'b0;
            timeout_flag <= 1'b0;
            sent_count   <= '0;
            abort_count  <= '0;
            rr_last      <= RR_RESET;
            timer        <= '0;
            gap_cnt      <= '0;
        end else begin
            done        <= '0;
            err         <= '0;
            send_packet <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable && arb_valid) begin
                        grant       <= NUM_REQ'(1) << winner;
                        send_packet <= 1'b1;
                        rr_last     <= winner;
                        timer       <= '0;
                        busy        <= 1'b1;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    timer <= timer + 1'b1;
                    // rr_last holds the owner for the whole frame.
                    if (packet_sent) begin
                        done[rr_last] <= 1'b1;
                        grant         <= '0;
                        sent_count    <= sent_count + 1'b1;
                        gap_cnt       <= '0;
                        busy          <= GAP_USED;
                        state         <= ST_AFTER;
                    end else if (timer == TMR_LAST) begin
                        err[rr_last]  <= 1'b1;
                        grant         <= '0;
                        timeout_flag  <= 1'b1;
                        if (abort_count != '1) begin
                            abort_count <= abort_count + 1'b1;
                        end
                        gap_cnt       <= '0;
                        busy          <= GAP_USED;
                        state         <= ST_AFTER;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Bench for udp_tx_scheduler: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a timestamp-based reference model.
module tb_udp_tx_scheduler;

    localparam int N   = 4;
    localparam int IFG = 12;
    localparam int TMO = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [N-1:0] req = '0;
    logic        packet_sent = 1'b0;
    logic [N-1:0] grant, done, err;
    logic        send_packet, busy, timeout_flag;
    logic [31:0] sent_count;
    logic [15:0] abort_count;
    logic [1:0]  state;

    udp_tx_scheduler #(
        .NUM_REQ        (N),
        .IFG_CYCLES     (IFG),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .req          (req),
        .grant        (grant),
        .done         (done),
        .err          (err),
        .send_packet  (send_packet),
        .packet_sent  (packet_sent),
        .busy         (busy),
        .timeout_flag (timeout_flag),
        .sent_count   (sent_count),
        .abort_count  (abort_count),
        .state        (state)
    );

    // ---------------- clock ----------------
    always #4 clk = ~clk;

    // ---------------- check / counters ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // A frame is described by its owner and the edge it was granted on; the
    // scheduler may sample requests again from edge m_free onward.
    int          m_owner = -1;
    int          m_send_edge = 0;
    int          m_free = 0;
    int          m_last = N - 1;
    logic [N-1:0] e_grant = '0, e_done = '0, e_err = '0;
    logic        e_send = 1'b0, e_busy = 1'b0, e_flag = 1'b0;
    logic [31:0] e_sent = '0;
    logic [15:0] e_abort = '0;

    always @(posedge clk) begin
        int w;
        cyc++;
        e_done = '0;
        e_err  = '0;
        e_send = 1'b0;
        if (rst) begin
            m_owner = -1;
            m_free  = cyc + 1;
            m_last  = N - 1;
            e_flag  = 1'b0;
            e_sent  = '0;
            e_abort = '0;
        end else if (m_owner >= 0) begin
            if (packet_sent) begin
                e_done[m_owner] = 1'b1;
                e_sent  = e_sent + 1;
                m_owner = -1;
                m_free  = cyc + 1 + IFG;
            end else if (cyc - m_send_edge == TMO) begin
                e_err[m_owner] = 1'b1;
                e_flag  = 1'b1;
                if (e_abort != 16'hFFFF) e_abort = e_abort + 1;
                m_owner = -1;
                m_free  = cyc + 1 + IFG;
            end
        end else if (cyc >= m_free && enable && req != '0) begin
            w = -1;
            for (int i = 1; i <= N; i++) begin
                if (w < 0 && req[(m_last + i) % N]) w = (m_last + i) % N;
            end
            m_owner     = w;
            m_last      = w;
            m_send_edge = cyc;
            e_send      = 1'b1;
        end
        e_grant = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        e_busy  = (m_owner >= 0) || (cyc < m_free - 1);
    end

    // ---------------- per-cycle scoreboard and event monitor ----------------
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int send_cyc = 0, done_cyc = 0, err_cyc = 0;
    int n_done = 0, n_err = 0;

    always @(negedge clk) begin
        check("grant",        grant,        e_grant);
        check("done",         done,         e_done);
        check("err",          err,          e_err);
        check("send_packet",  send_packet,  e_send);
        check("busy",         busy,         e_busy);
        check("timeout_flag", timeout_flag, e_flag);
        check("sent_count",   sent_count,   e_sent);
        check("abort_count",  abort_count,  e_abort);
        if (send_packet) begin
            for (int i = 0; i < N; i++) if (grant[i]) got_q.push_back(8'(i));
            send_cyc = cyc;
        end
        if (done != '0) begin done_cyc = cyc; n_done++; end
        if (err  != '0) begin err_cyc  = cyc; n_err++;  end
    end

    // ---------------- driver ----------------
    int tx_lat = 0;   // packet_sent this many clocks after send_packet; 0 = never
    int tx_cnt = 0;
    bit spur   = 1'b0;
    bit drop1  = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
        packet_sent = 1'b0;
        if (rst) tx_cnt = 0;
        else if (send_packet) tx_cnt = tx_lat;
        else if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) packet_sent = 1'b1;
        end
        if (spur) begin packet_sent = 1'b1; spur = 1'b0; end
        if (drop1 && done[1]) begin req[1] = 1'b0; drop1 = 1'b0; end
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tx_cnt = 0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    // sel: 0 = grants issued, 1 = done pulses, 2 = err pulses
    task automatic wait_ev(input int sel, input int n, input int budget, input string tag);
        int k = 0;
        int cur;
        cur = (sel == 0) ? got_q.size() : (sel == 1) ? n_done : n_err;
        while (cur < n && k < budget) begin
            step();
            k++;
            cur = (sel == 0) ? got_q.size() : (sel == 1) ? n_done : n_err;
        end
        check(tag, cur, n);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base, s1, nd, ne;

        // Reset state
        do_reset();
        check("rst_grant", grant, 0);
        check("rst_send", send_packet, 0);
        check("rst_busy", busy, 0);
        check("rst_state", state, 0);
        check("rst_counts", sent_count + abort_count, 0);

        // Single request, transmitter answers 80 clocks after send_packet
        enable = 1'b1;
        tx_lat = 80;
        repeat (10) step();
        req = 4'b0001;
        base = cyc;
        got_q.delete();
        wait_ev(0, 1, 50, "t1_wait_send");
        s1 = send_cyc;
        check("t1_send_cyc", s1 - base, 1);
        wait_ev(1, n_done + 1, 200, "t1_wait_done");
        check("t1_done_cyc", done_cyc - base, 82);
        check("t1_sent_count", sent_count, 1);
        wait_ev(0, 2, 200, "t1_wait_regrant");
        check("t1_regrant_gap", send_cyc - s1, 80 + 1 + IFG + 1);
        req = '0;

        // Round-robin order with 1011 held
        do_reset();
        tx_lat = int'($urandom_range(1, 20));
        req = 4'b1011;
        got_q.delete();
        wait_ev(0, 6, 1000, "rr_wait");
        exp_q = '{8'd0, 8'd1, 8'd3, 8'd0, 8'd1, 8'd3};
        for (int i = 0; i < 6; i++) check("rr_order", got_q[i], exp_q[i]);

        // Requester 1 drops after its first done
        do_reset();
        tx_lat = int'($urandom_range(1, 20));
        req = 4'b1011;
        drop1 = 1'b1;
        got_q.delete();
        wait_ev(0, 6, 1000, "rr_drop_wait");
        exp_q = '{8'd0, 8'd1, 8'd3, 8'd0, 8'd3, 8'd0};
        for (int i = 0; i < 6; i++) check("rr_drop_order", got_q[i], exp_q[i]);
        drop1 = 1'b0;

        // Timeout, transmitter never answers
        do_reset();
        tx_lat = 0;
        req = 4'b0001;
        got_q.delete();
        ne = n_err;
        wait_ev(2, ne + 1, TMO + 100, "tmo_wait_err");
        check("tmo_err_cyc", err_cyc - send_cyc, TMO);
        check("tmo_flag", timeout_flag, 1);
        check("tmo_abort", abort_count, 1);
        check("tmo_sent", sent_count, 0);
        tx_lat = 5;
        wait_ev(0, 2, 100, "tmo_resume");
        check("tmo_resume_cyc", send_cyc - err_cyc, IFG + 1);
        wait_ev(1, n_done + 1, 100, "tmo_done");

        // packet_sent on the timer's last cycle wins over the abort
        tx_lat = TMO - 1;
        ne = n_err;
        wait_ev(1, n_done + 1, TMO + 100, "coinc_done");
        check("coinc_done_cyc", done_cyc - send_cyc, TMO);
        check("coinc_no_err", n_err, ne);
        check("coinc_abort", abort_count, 1);
        check("coinc_sent", sent_count, 2);
        req = '0;

        // Gating by enable and a spurious packet_sent in IDLE
        do_reset();
        enable = 1'b0;
        req = 4'b1111;
        got_q.delete();
        repeat (1000) step();
        check("gate_sends", got_q.size(), 0);
        nd = n_done;
        spur = 1'b1;
        repeat (2) step();
        check("spur_sent", sent_count, 0);
        check("spur_done", n_done, nd);
        tx_lat = 3;
        enable = 1'b1;
        base = cyc;
        wait_ev(0, 1, 10, "en_wait");
        check("en_send_cyc", send_cyc - base, 1);
        check("en_owner", got_q[0], 0);

        // Reset 30 clocks into WAIT
        wait_ev(1, n_done + 1, 50, "pre_rst_done");
        req = 4'b0010;
        tx_lat = 0;
        got_q.delete();
        wait_ev(0, 1, 50, "mid_wait_grant");
        check("mid_owner", got_q[0], 1);
        repeat (30) step();
        nd = n_done;
        ne = n_err;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_grant", grant, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_state", state, 0);
        check("mid_rst_pulses", n_done + n_err, nd + ne);
        req = 4'b1111;
        got_q.delete();
        wait_ev(0, 1, 10, "post_rst_grant");
        check("post_rst_owner", got_q[0], 0);

        // Randomized traffic
        do_reset();
        for (int k = 0; k < 6000; k++) begin
            if ($urandom_range(0, 7) == 0) req = N'($urandom_range(0, 15));
            enable = ($urandom_range(0, 19) != 0);
            tx_lat = ($urandom_range(0, 399) == 0) ? 0 : int'($urandom_range(1, 25));
            if ($urandom_range(0, 99) == 0) spur = 1'b1;
            rst = ($urandom_range(0, 1499) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
